snow64_sliced_alu_sequencer: RTL
================================

# snow64_sliced_alu_sequencer

Multi-cycle sequencer that applies one ALU operation across a 64-bit operand pair, one slice per cycle. Slice width is 8, 16, 32 or 64 bits, matching the team's sliced-data layouts (8×8, 4×16, 2×32, 1×64). The block sits between the instruction-issue stage and the register writeback path. Valid/ready handshakes on both sides let it share a single narrow slice datapath under back-pressure.

## Interface
- Parameters: none. Widths are fixed: 64-bit operands, slice widths 8/16/32/64.
- clk  in  1  Clock; all state updates on rising edge.
- rst_n  in  1  Reset, asynchronous, active-low.
- in_valid  in  1  Request valid.
- in_ready  out  1  Request accepted when in_valid && in_ready.
- in_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLTU, 6 SLTS, 7 PASS_A.
- in_int_type_size  in  2  Slice width: 0 = 8, 1 = 16, 2 = 32, 3 = 64.
- in_a, in_b  in  64  Operands; slice i occupies bits [i*w +: w].
- out_valid  out  1  Result valid; held until accepted.
- out_ready  in  1  Consumer accepts when out_valid && out_ready.
- out_data  out  64  Result; same slice layout as the inputs.
- out_busy  out  1  High in BUSY.

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- in_ready = (state == IDLE) && rst_n.
- IDLE, on accept:
  - latch op, size, a and b;
  - set the slice count N to 8/4/2/1;
  - clear slice_idx and the result register to 0;
  - go to BUSY.
- BUSY, each cycle:
  - compute slice slice_idx of a and b and write it into the result register;
  - if slice_idx == N-1, go to DONE; else increment slice_idx.
- DONE: out_valid = 1. On out_ready, go to IDLE.
- There is no accept in the same cycle as the DONE→IDLE transition.
- Arithmetic is per slice, modulo 2^w:
  - carry and borrow never cross slice boundaries;
  - AND/OR/XOR are bitwise;
  - PASS_A copies slice a.
- Compares: SLTU/SLTS write 1 into the slice LSB when a < b; all other slice bits are 0.
- Every slice is written, so no result bits are left undefined.
- in_* is ignored outside IDLE. Operands are latched, so later input changes do not affect the current operation.
- Reset values: state IDLE, slice_idx 0, result 0, out_valid 0, out_data 0, out_busy 0, in_ready 0 while rst_n is low.
- Reset asserted mid-operation: FSM returns to IDLE immediately and asynchronously, and the partial result is discarded. Nothing is emitted after release.

## Timing
- Accept at edge T. Slices are written at edges T+1 … T+N. out_valid rises after edge T+N, so it is first sampled high in cycle T+N+1.
- Latency from accept to out_valid is N+1 cycles: 9 for 8-bit, 5 for 16-bit, 3 for 32-bit, 2 for 64-bit.
- With out_ready held high, the result is consumed at its first valid edge and in_ready rises the following cycle. Peak throughput is one operation per N+2 cycles.
- out_valid and out_data stay stable for as long as out_ready is low.
- out_data is registered; no combinational path runs from in_* to out_*.

## Configuration
- SNOW64_SLICED_SEQ_SIGNED_CMP_EN
  - Defined: op 6 is SLTS, a two's-complement signed compare per slice.
  - Undefined: the signed-compare logic is omitted and op 6 behaves exactly as SLTU. All other ops are unchanged.

## Test plan
- Reset:
  - rst_n low → in_ready 0, out_valid 0, out_data 0, out_busy 0;
  - release → in_ready 1 next cycle.
- ADD, size 0:
  - a = 0x0102030405060708, b = 0x01010101010101FF;
  - → out_data 0x0203040506070807 (no carry from slice 0), out_valid in cycle T+9.
- SUB, size 3:
  - a = 0, b = 1;
  - → out_data 0xFFFFFFFFFFFFFFFF, out_valid in cycle T+2.
- SLTS, size 1:
  - a = 0x8000000170000000, b = 0x0000000280000000;
  - with the macro → 0x0001000100000000;
  - without the macro (behaves as SLTU) → 0x0000000100010000.
- Back-pressure:
  - XOR, size 2, out_ready held low 5 cycles;
  - → out_valid and out_data stable, in_ready 0, in_valid pulses ignored;
  - out_ready high → IDLE next cycle.
- Reset mid-operation:
  - deassert rst_n during the 3rd BUSY cycle of a size-0 ADD;
  - → out_valid never asserts for that request, out_busy 0 immediately;
  - after release, a fresh request completes with the correct value.

Source files
------------

// File: rtl/snow64_sliced_alu_sequencer_if.sv
// Request/response bundle between the issue stage, the sliced ALU sequencer
// and the writeback path.
interface snow64_sliced_alu_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [1:0]  in_int_type_size;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_busy;

   modport master (
      output in_valid, in_op, in_int_type_size, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data, out_busy
   );

   modport slave (
      input  in_valid, in_op, in_int_type_size, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data, out_busy
   );
endinterface

// File: rtl/snow64_sliced_alu_sequencer.sv
// Applies one ALU op to a 64-bit operand pair, one 8/16/32/64-bit slice per cycle.
// Optional: SNOW64_SLICED_SEQ_SIGNED_CMP_EN enables signed compare for op 6.
module snow64_sliced_alu_sequencer (
   input  logic                                clk,
   input  logic                                rst_n,
   snow64_sliced_alu_sequencer_if.slave        bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic        w_accept;

   logic [2:0]  r_op;
   logic [1:0]  r_size;
   logic [63:0] r_a;
   logic [63:0] r_b;
   logic [2:0]  r_idx;
   logic [63:0] r_result;

   logic [6:0]  w_shift;
   logic [63:0] w_mask;
   logic [63:0] w_sign;
   logic        w_last;
   logic [63:0] w_sa;
   logic [63:0] w_sb;
   logic        w_ltu;
   logic [63:0] w_res;

   // Slice geometry derived from the latched size and current slice index.
   always_comb begin
      w_shift = 7'd0;
      w_mask  = '1;
      w_sign  = 64'h8000_0000_0000_0000;
      w_last  = 1'b1;
      case (r_size)
         2'd0: begin
            w_shift = {1'b0, r_idx, 3'b000};
            w_mask  = 64'h0000_0000_0000_00FF;
            w_sign  = 64'h0000_0000_0000_0080;
            w_last  = (r_idx == 3'd7);
         end
         2'd1: begin
            w_shift = {1'b0, r_idx[1:0], 4'b0000};
            w_mask  = 64'h0000_0000_0000_FFFF;
            w_sign  = 64'h0000_0000_0000_8000;
            w_last  = (r_idx == 3'd3);
         end
         2'd2: begin
            w_shift = {1'b0, r_idx[0], 5'b00000};
            w_mask  = 64'h0000_0000_FFFF_FFFF;
            w_sign  = 64'h0000_0000_8000_0000;
            w_last  = (r_idx == 3'd1);
         end
         default: begin
            w_shift = 7'd0;
            w_mask  = '1;
            w_sign  = 64'h8000_0000_0000_0000;
            w_last  = (r_idx == 3'd0);
         end
      endcase
   end

   assign w_sa  = (r_a >> w_shift) & w_mask;
   assign w_sb  = (r_b >> w_shift) & w_mask;
   assign w_ltu = (w_sa < w_sb);

`ifdef SNOW64_SLICED_SEQ_SIGNED_CMP_EN
   logic w_lts;
   // Flipping the slice sign bit maps two's-complement order onto unsigned order.
   assign w_lts = ((w_sa ^ w_sign) < (w_sb ^ w_sign));
`else
   logic w_sign_unused;
   assign w_sign_unused = ^w_sign;
`endif

   always_comb begin
      w_res = 64'd0;
      case (r_op)
         3'd0: w_res = (w_sa + w_sb) & w_mask;
         3'd1: w_res = (w_sa - w_sb) & w_mask;
         3'd2: w_res = w_sa & w_sb;
         3'd3: w_res = w_sa | w_sb;
         3'd4: w_res = w_sa ^ w_sb;
         3'd5: w_res = {63'd0, w_ltu};
`ifdef SNOW64_SLICED_SEQ_SIGNED_CMP_EN
         3'd6: w_res = {63'd0, w_lts};
`else
         3'd6: w_res = {63'd0, w_ltu};
`endif
         default: w_res = w_sa;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.in_valid) begin
               w_accept     = 1'b1;
               w_state_next = BUSY;
            end
         end
         BUSY: begin
            if (w_last) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_op     <= 3'd0;
         r_size   <= 2'd0;
         r_a      <= 64'd0;
         r_b      <= 64'd0;
         r_idx    <= 3'd0;
         r_result <= 64'd0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_op     <= bus.in_op;
            r_size   <= bus.in_int_type_size;
            r_a      <= bus.in_a;
            r_b      <= bus.in_b;
            r_idx    <= 3'd0;
            r_result <= 64'd0;
         end else if (r_state == BUSY) begin
            r_result <= (r_result & ~(w_mask << w_shift)) | (w_res << w_shift);
            if (!w_last) begin
               r_idx <= r_idx + 3'd1;
            end
         end
      end
   end

   assign bus.in_ready  = (r_state == IDLE) && rst_n;
   assign bus.out_valid = (r_state == DONE);
   assign bus.out_busy  = (r_state == BUSY);
   assign bus.out_data  = r_result;

endmodule
